// File: rtl/spi_packet_pkg.sv
// Shared types and constants for the SPI packet host.
package spi_packet_pkg;

  localparam int DEFAULT_DEPTH = 64;

  typedef logic [7:0] byte_t;

  localparam byte_t ERR_SAT = 8'hFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_HDR  = 3'd1,
    SEND_DATA = 3'd2,
    WAIT_HDR  = 3'd3,
    RECV_DATA = 3'd4,
    FINISH    = 3'd5
  } state_e;

endpackage

// File: rtl/spi_packet_buffer.sv
// Payload register file: one synchronous write port, one asynchronous read port.
module spi_packet_buffer
  import spi_packet_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     wen,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  byte_t                    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output byte_t                    rdata
);

  byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_packet_host.sv
// Sends a length-prefixed payload frame, then checks the echoed frame byte-for-byte.
// Optional receive watchdog (timeout output) enabled by SPI_PACKET_HOST_TIMEOUT_EN.
module spi_packet_host
  import spi_packet_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
`ifdef SPI_PACKET_HOST_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [7:0]               load_data,
  input  logic                     start,
  input  logic [7:0]               len,
  output logic                     ready,
  output logic                     write,
  output logic [7:0]               byte_send,
  input  logic                     busy,
  input  logic [7:0]               byte_recv,
  input  logic                     valid,
  output logic                     done,
  output logic                     mismatch,
  output logic                     len_err,
  output logic [7:0]               err_count
`ifdef SPI_PACKET_HOST_TIMEOUT_EN
  , output logic                   timeout
`endif
);

  localparam int AW = $clog2(DEPTH);

  state_e          state;
  byte_t           hdr;
  logic [AW-1:0]   index;
  byte_t           rd_byte;
  byte_t           err_next;
  logic            len_bad;
  logic            at_last;
  logic            tx_slot;

`ifdef SPI_PACKET_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          timed_out;
  assign timed_out = (wait_cnt == TW'(TIMEOUT_CYCLES));
`endif

  assign ready    = (state == IDLE);
  assign len_bad  = (len == 8'd0) || (int'(len) > DEPTH - 1);
  assign at_last  = (index == hdr[AW-1:0]);
  // The write==0 term guarantees an idle cycle between strobes.
  assign tx_slot  = !busy && !write;
  assign err_next = (err_count == ERR_SAT) ? ERR_SAT : err_count + 8'd1;

  spi_packet_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .wen   (load && ready),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (index),
    .rdata (rd_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hdr       <= '0;
      index     <= '0;
      write     <= 1'b0;
      byte_send <= '0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      len_err   <= 1'b0;
      err_count <= '0;
`ifdef SPI_PACKET_HOST_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      write <= 1'b0;
      done  <= 1'b0;
`ifdef SPI_PACKET_HOST_TIMEOUT_EN
      if (state == WAIT_HDR || state == RECV_DATA) wait_cnt <= wait_cnt + TW'(1);
`endif
      case (state)
        IDLE: begin
          if (start) begin
            mismatch  <= 1'b0;
            err_count <= '0;
`ifdef SPI_PACKET_HOST_TIMEOUT_EN
            timeout   <= 1'b0;
`endif
            if (len_bad) begin
              done    <= 1'b1;
              len_err <= 1'b1;
            end else begin
              len_err <= 1'b0;
              hdr     <= len;
              index   <= '0;
              state   <= SEND_HDR;
            end
          end
        end
        SEND_HDR: begin
          if (tx_slot) begin
            write     <= 1'b1;
            byte_send <= hdr;
            state     <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (tx_slot) begin
            write     <= 1'b1;
            byte_send <= rd_byte;
            if (at_last) begin
              index <= '0;
              state <= WAIT_HDR;
`ifdef SPI_PACKET_HOST_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              index <= index + AW'(1);
            end
          end
        end
        WAIT_HDR: begin
          if (valid) begin
            if (byte_recv != hdr) begin
              mismatch  <= 1'b1;
              err_count <= err_next;
            end
            state <= RECV_DATA;
`ifdef SPI_PACKET_HOST_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (timed_out) begin
            timeout  <= 1'b1;
            mismatch <= 1'b1;
            state    <= FINISH;
`endif
          end
        end
        RECV_DATA: begin
          // The received header never changes how many payload bytes are taken.
          if (valid) begin
            if (byte_recv != rd_byte) begin
              mismatch  <= 1'b1;
              err_count <= err_next;
            end
            if (at_last) state <= FINISH;
            else         index <= index + AW'(1);
`ifdef SPI_PACKET_HOST_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (timed_out) begin
            timeout  <= 1'b1;
            mismatch <= 1'b1;
            state    <= FINISH;
`endif
          end
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_packet_host.sv
// Randomized bench for spi_packet_host, checked against a frame-level reference model.
module tb_spi_packet_host;
  import spi_packet_pkg::*;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [5:0] load_addr = '0;
  byte_t      load_data = '0;
  logic       start = 1'b0;
  byte_t      len = '0;
  logic       ready, write, done, mismatch, len_err;
  byte_t      byte_send, err_count;
  logic       busy = 1'b0;
  byte_t      byte_recv = '0;
  logic       valid = 1'b0;
`ifdef SPI_PACKET_HOST_TIMEOUT_EN
  logic       timeout;
`endif

  int checks = 0;
  int errors = 0;

  byte_t mirror [DEPTH];
  byte_t txq [$];
  byte_t exp_tx [$];
  logic  busy_q = 1'b0;
  logic  prev_write = 1'b0;

  always #5 clk = ~clk;

  spi_packet_host #(
    .DEPTH(DEPTH)
`ifdef SPI_PACKET_HOST_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .len       (len),
    .ready     (ready),
    .write     (write),
    .byte_send (byte_send),
    .busy      (busy),
    .byte_recv (byte_recv),
    .valid     (valid),
    .done      (done),
    .mismatch  (mismatch),
    .len_err   (len_err),
    .err_count (err_count)
`ifdef SPI_PACKET_HOST_TIMEOUT_EN
    , .timeout (timeout)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Byte-engine side: capture every strobe, and police busy and strobe spacing.
  always @(posedge clk) busy_q <= busy;

  always @(negedge clk) begin
    if (write) begin
      check("tx_while_busy", busy_q, 0);
      check("tx_back_to_back", prev_write, 0);
      txq.push_back(byte_send);
    end
    prev_write = write;
  end

  // Loads buffer[0..h] (last byte together with start) and collects the frame.
  // bmode: 0 no busy, 1 busy held 10 cycles after header, 2 random busy.
  task automatic send_frame(input int h, input int bmode, input bit directed);
    byte_t d;
    int cyc;
    int bp_left;
    bit bp_done;
    txq.delete();
    for (int i = 0; i <= h; i++) begin
      d = directed ? byte_t'(8'h11 * (i + 1)) : byte_t'($urandom);
      mirror[i] = d;
      load = 1'b1;
      load_addr = 6'(i);
      load_data = d;
      if (i == h) begin
        start = 1'b1;
        len = byte_t'(h);
      end
      tick();
    end
    load = 1'b0;
    start = 1'b0;
    exp_tx.delete();
    exp_tx.push_back(byte_t'(h));
    for (int i = 0; i <= h; i++) exp_tx.push_back(mirror[i]);

    cyc = 0;
    bp_left = 0;
    bp_done = 1'b0;
    while (txq.size() < h + 2 && cyc < 3000) begin
      // Inputs that must be ignored outside IDLE / outside the receive states.
      valid = ($urandom_range(0, 5) == 0);
      byte_recv = 8'hAA;
      load = ($urandom_range(0, 5) == 0);
      load_addr = '0;
      load_data = ~mirror[0];
      start = ($urandom_range(0, 5) == 0);
      len = 8'd5;
      if (bmode == 1) begin
        if (txq.size() == 1 && !bp_done) begin
          bp_done = 1'b1;
          bp_left = 10;
        end
        busy = (bp_left > 0);
        if (bp_left > 0) bp_left--;
      end else if (bmode == 2) begin
        busy = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
    end
    valid = 1'b0;
    load = 1'b0;
    start = 1'b0;
    busy = 1'b0;
    check("tx_count", txq.size(), h + 2);
    for (int i = 0; i < exp_tx.size(); i++)
      check("tx_byte", (i < txq.size()) ? 32'(txq[i]) : 32'hDEAD, 32'(exp_tx[i]));
  endtask

  // cmode: 0 clean echo, 1 random corruption, 2 positions 2 and 4 forced to FF / 00.
  task automatic echo(input int cmode);
    byte_t b;
    int nerr;
    nerr = 0;
    for (int i = 0; i < exp_tx.size(); i++) begin
      b = exp_tx[i];
      if (cmode == 1 && $urandom_range(0, 3) == 0) b = b ^ byte_t'($urandom_range(1, 255));
      if (cmode == 2 && i == 2) b = 8'hFF;
      if (cmode == 2 && i == 4) b = 8'h00;
      if (b != exp_tx[i]) nerr++;
      repeat ($urandom_range(0, 2)) tick();
      valid = 1'b1;
      byte_recv = b;
      tick();
      valid = 1'b0;
    end
    check("done_early", done, 0);
    tick();
    check("done_pulse", done, 1);
    check("mismatch", mismatch, (nerr != 0) ? 1 : 0);
    check("err_count", err_count, (nerr > 255) ? 255 : nerr);
    check("len_err_clear", len_err, 0);
`ifdef SPI_PACKET_HOST_TIMEOUT_EN
    check("timeout_clear", timeout, 0);
`endif
    tick();
    check("done_one_cycle", done, 0);
    check("ready_after", ready, 1);
  endtask

  task automatic illegal(input byte_t l);
    txq.delete();
    start = 1'b1;
    len = l;
    tick();
    start = 1'b0;
    check("ill_done", done, 1);
    check("ill_len_err", len_err, 1);
    check("ill_mismatch", mismatch, 0);
    check("ill_err_count", err_count, 0);
    check("ill_ready", ready, 1);
    repeat (5) tick();
    check("ill_done_low", done, 0);
    check("ill_no_tx", txq.size(), 0);
  endtask

  initial begin
    int h, sz;
    bit seen;
    rst = 1'b1;
    repeat (2) tick();
    check("rst_write", write, 0);
    check("rst_byte_send", byte_send, 0);
    check("rst_done", done, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_len_err", len_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_ready", ready, 1);
    rst = 1'b0;
    tick();

    send_frame(3, 0, 1);
    echo(0);
    send_frame(3, 0, 1);
    echo(2);
    illegal(8'd0);
    illegal(8'd64);
    illegal(8'd255);
    send_frame(5, 1, 0);
    echo(0);
    send_frame(1, 2, 0);
    echo(1);
    send_frame(63, 2, 0);
    echo(1);
    for (int t = 0; t < 8; t++) begin
      h = $urandom_range(1, 63);
      send_frame(h, ($urandom_range(0, 1) == 1) ? 2 : 0, 1'b0);
      echo(int'($urandom_range(0, 1)));
    end

    // Reset in the middle of the receive phase.
    send_frame(4, 0, 0);
    valid = 1'b1;
    byte_recv = exp_tx[0];
    tick();
    byte_recv = ~exp_tx[1];
    tick();
    valid = 1'b0;
    tick();
    check("pre_rst_err", err_count, 1);
    rst = 1'b1;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_mismatch", mismatch, 0);
    tick();
    rst = 1'b0;
    sz = txq.size();
    repeat (4) tick();
    check("midrst_no_tx", txq.size(), sz);
    send_frame(6, 0, 0);
    echo(0);

`ifdef SPI_PACKET_HOST_TIMEOUT_EN
    send_frame(2, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("to_done", seen, 1);
    check("to_timeout", timeout, 1);
    check("to_mismatch", mismatch, 1);
    tick();
    check("to_ready", ready, 1);
`else
    seen = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
